// File: rtl/seg_counter_display.sv
// Parametrised hex/BCD up/down counter with a prescaled count tick and a
// multiplexed, active-low 7-segment driver with optional leading-zero blanking.
module seg_counter_display #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 250000,
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          LZB      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  mode_bcd,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   value,
  output logic                  wrap,
  output logic [DIGITS-1:0]     sel,
  output logic [6:0]            seg
);

  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  logic [PW-1:0] presc;
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  logic          mode_q;
  logic          tick;

  logic [VW-1:0]     hex_next;
  logic [VW-1:0]     bcd_next;
  logic              carry;
  logic [3:0]        dig;
  logic              at_max;
  logic              at_zero;
  logic              wrap_hit;
  logic [DIGITS-1:0] blank;
  logic              higher_zero;
  logic [3:0]        cur_digit;
  logic              cur_blank;
  logic [DIGITS-1:0] sel_next;

  assign tick = en && (presc == PRE_LAST);

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Next-count candidates: whole-word hex step and per-digit BCD ripple.
  always_comb begin
    hex_next = up_dn ? (value + VW'(1)) : (value - VW'(1));
    bcd_next = value;
    carry    = 1'b1;
    dig      = 4'h0;
    at_max   = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = value[4*i +: 4];
      if (dig != (mode_q ? 4'h9 : 4'hF)) at_max = 1'b0;
      if (carry) begin
        if (up_dn) begin
          if (dig == 4'h9) begin
            bcd_next[4*i +: 4] = 4'h0;
            carry              = 1'b1;
          end else begin
            bcd_next[4*i +: 4] = dig + 4'h1;
            carry              = 1'b0;
          end
        end else begin
          if (dig == 4'h0) begin
            bcd_next[4*i +: 4] = 4'h9;
            carry              = 1'b1;
          end else begin
            bcd_next[4*i +: 4] = dig - 4'h1;
            carry              = 1'b0;
          end
        end
      end
    end
    at_zero  = (value == '0);
    wrap_hit = up_dn ? at_max : at_zero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc  <= '0;
      value  <= '0;
      wrap   <= 1'b0;
      mode_q <= mode_bcd;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        value <= '0;
        presc <= '0;
      end else if (mode_bcd != mode_q) begin
        // Restart from zero so hex digits never leak into BCD counting.
        value  <= '0;
        presc  <= '0;
        mode_q <= mode_bcd;
      end else if (en) begin
        if (tick) begin
          presc <= '0;
          value <= mode_q ? bcd_next : hex_next;
          wrap  <= wrap_hit;
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  // A digit blanks when it and every digit above it are zero; digit 0 never does.
  always_comb begin
    higher_zero = 1'b1;
    blank       = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      higher_zero = higher_zero && (value[4*(DIGITS-1-k) +: 4] == 4'h0);
      blank[DIGITS-1-k] = LZB && (k != DIGITS - 1) && higher_zero;
    end
  end

  always_comb begin
    cur_digit = 4'h0;
    cur_blank = 1'b0;
    sel_next  = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_digit   = value[4*i +: 4];
        cur_blank   = blank[i];
        sel_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      sel      <= '1;
      seg      <= 7'h7F;
    end else begin
      sel <= sel_next;
      seg <= cur_blank ? 7'h7F : dec7(cur_digit);
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_counter_display.sv
// Randomised and directed bench for seg_counter_display against a decimal/hex
// arithmetic model; two instances differ only in leading-zero blanking.
module tb_seg_counter_display;

  localparam int D  = 4;
  localparam int TD = 4;
  localparam int SD = 2;

  logic clk = 1'b0;
  logic rst, en, up_dn, mode_bcd, clr;
  logic [15:0] a_value, b_value;
  logic        a_wrap, b_wrap;
  logic [3:0]  a_sel, b_sel;
  logic [6:0]  a_seg, b_seg;

  int checks   = 0;
  int failures = 0;

  seg_counter_display #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD), .LZB(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode_bcd(mode_bcd), .clr(clr),
    .value(a_value), .wrap(a_wrap), .sel(a_sel), .seg(a_seg));

  seg_counter_display #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD), .LZB(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode_bcd(mode_bcd), .clr(clr),
    .value(b_value), .wrap(b_wrap), .sel(b_sel), .seg(b_seg));

  always #5 clk = ~clk;

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    int m = 1;
    for (int i = 0; i < D; i++) begin
      r += int'(v[4*i +: 4]) * m;
      m *= 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r = '0;
    int x = n;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x /= 10;
    end
    return r;
  endfunction

  function automatic logic bcd_ok(input logic [15:0] v);
    logic ok = 1'b1;
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // Reference model: count as a number (decimal or binary), display index as
  // (cycles since reset / SCAN_DIV) mod DIGITS, outputs lag state by one cycle.
  logic [15:0] m_val;
  int          m_pre, m_cyc;
  logic        m_mode, m_wrap, m_valid = 1'b0;
  logic [3:0]  m_sel;
  logic [6:0]  m_seg_a, m_seg_b;

  always @(posedge clk) begin : model
    int di;
    int dec;
    logic [3:0] d;
    if (rst) begin
      m_val = '0; m_pre = 0; m_cyc = 0; m_wrap = 1'b0;
      m_sel = 4'hF; m_seg_a = 7'h7F; m_seg_b = 7'h7F;
      m_mode = mode_bcd; m_valid = 1'b1;
    end else begin
      di = (m_cyc / SD) % D;
      m_sel = 4'hF;
      m_sel[di] = 1'b0;
      d = m_val[4*di +: 4];
      m_seg_b = segtab[d];
      m_seg_a = (di != 0 && (m_val >> (4*di)) == 16'h0) ? 7'h7F : segtab[d];
      m_cyc++;
      m_wrap = 1'b0;
      if (clr) begin
        m_val = '0; m_pre = 0;
      end else if (mode_bcd != m_mode) begin
        m_val = '0; m_pre = 0; m_mode = mode_bcd;
      end else if (en) begin
        if (m_pre == TD - 1) begin
          m_pre = 0;
          if (m_mode) begin
            dec = bcd2int(m_val);
            m_wrap = up_dn ? (dec == 9999) : (dec == 0);
            m_val = int2bcd(up_dn ? (dec + 1) % 10000 : (dec + 9999) % 10000);
          end else begin
            m_wrap = up_dn ? (m_val == 16'hFFFF) : (m_val == 16'h0000);
            m_val = up_dn ? m_val + 16'd1 : m_val - 16'd1;
          end
        end else begin
          m_pre++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("a_value", a_value, m_val);
      check("a_wrap", a_wrap, m_wrap);
      check("a_sel", a_sel, m_sel);
      check("a_seg", a_seg, m_seg_a);
      check("b_value", b_value, m_val);
      check("b_wrap", b_wrap, m_wrap);
      check("b_sel", b_sel, m_sel);
      check("b_seg", b_seg, m_seg_b);
      if (m_mode) check("bcd_digits", bcd_ok(a_value), 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_wrap(input int bound, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_wrap && n < bound);
    if (!a_wrap) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: actual=no wrap required=wrap within %0d cycles", name, bound);
    end
  endtask

  task automatic wait_sel(input logic [3:0] s, input logic want_eq, input int bound);
    int n = 0;
    while (((a_sel == s) != want_eq) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if ((a_sel == s) != want_eq) begin
      checks++;
      failures++;
      $display("FAIL scan_sync timeout: actual=%b required=%s %b", a_sel, want_eq ? "==" : "!=", s);
    end
  endtask

  logic [3:0] exp_sel  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] exp_sega [4] = '{7'h12, 7'h40, 7'h30, 7'h7F};
  logic [6:0] exp_segb [4] = '{7'h12, 7'h40, 7'h30, 7'h40};

  initial begin
    rst = 1'b1; en = 1'b1; up_dn = 1'b1; mode_bcd = 1'b0; clr = 1'b0;
    cyc(3);
    check("rst_value", a_value, 16'h0000);
    check("rst_sel", a_sel, 4'hF);
    check("rst_seg", a_seg, 7'h7F);
    check("rst_wrap", a_wrap, 1'b0);
    rst = 1'b0;

    // Hex up: one step per TICK_DIV cycles from reset.
    cyc(17 * TD);
    check("hex_up_0011", a_value, 16'h0011);
    en = 1'b0;
    cyc(10);
    check("en_hold", a_value, 16'h0011);
    en = 1'b1;

    // Down through zero to FFFF, then up through FFFF to 0000.
    up_dn = 1'b0;
    wait_wrap(200, "down_wrap");
    check("hex_down_wrap", a_value, 16'hFFFF);
    up_dn = 1'b1;
    wait_wrap(20, "up_wrap");
    check("hex_up_wrap", a_value, 16'h0000);
    cyc(1);
    check("wrap_one_cycle", a_wrap, 1'b0);

    // clr coinciding with a tick: cleared, no wrap, next tick TICK_DIV later.
    cyc(2 * TD);
    for (int n = 0; n < TD && m_pre != TD - 1; n++) cyc(1);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    check("clr_tick_value", a_value, 16'h0000);
    check("clr_tick_wrap", a_wrap, 1'b0);
    cyc(TD - 1);
    check("clr_tick_hold", a_value, 16'h0000);
    cyc(1);
    check("clr_tick_next", a_value, 16'h0001);

    // BCD: mode change clears, 0099 -> 0100, 0000 down -> 9999.
    mode_bcd = 1'b1;
    cyc(1);
    check("mode_clear", a_value, 16'h0000);
    cyc(99 * TD);
    check("bcd_0099", a_value, 16'h0099);
    cyc(TD);
    check("bcd_0100", a_value, 16'h0100);
    clr = 1'b1; up_dn = 1'b0;
    cyc(1);
    clr = 1'b0;
    wait_wrap(20, "bcd_down_wrap");
    check("bcd_down_9999", a_value, 16'h9999);

    for (int t = 0; t < 5000; t++) begin
      up_dn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        en = 1'b0;
        cyc($urandom_range(1, 5));
        en = 1'b1;
      end
      if ($urandom_range(0, 63) == 0) begin
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) mode_bcd = ~mode_bcd;
      cyc(TD);
    end

    // Hex to 00AF, then toggle mode.
    mode_bcd = 1'b0; up_dn = 1'b1; en = 1'b1;
    cyc(1);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(175 * TD);
    check("hex_00af", a_value, 16'h00AF);
    mode_bcd = 1'b1;
    cyc(1);
    check("toggle_value", a_value, 16'h0000);
    check("toggle_wrap", a_wrap, 1'b0);

    // Scan pattern for 0305 with and without blanking.
    mode_bcd = 1'b0;
    cyc(1);
    cyc(16'h0305 * TD);
    check("hex_0305", a_value, 16'h0305);
    en = 1'b0;
    cyc(2);
    wait_sel(4'b0111, 1'b1, 20);
    wait_sel(4'b0111, 1'b0, 5);
    for (int k = 0; k < 8; k++) begin
      check("scan_sel", a_sel, exp_sel[k/2]);
      check("scan_seg_lzb", a_seg, exp_sega[k/2]);
      check("scan_seg_nolzb", b_seg, exp_segb[k/2]);
      cyc(1);
    end

    // Reset mid-count and mid-scan.
    en = 1'b1;
    cyc(7);
    rst = 1'b1;
    cyc(1);
    check("mid_rst_value", a_value, 16'h0000);
    check("mid_rst_sel", a_sel, 4'hF);
    check("mid_rst_seg", a_seg, 7'h7F);
    check("mid_rst_wrap", a_wrap, 1'b0);
    rst = 1'b0;
    cyc(1);
    check("restart_sel0", a_sel, 4'b1110);
    check("restart_seg0", a_seg, 7'h40);
    cyc(1);
    check("restart_sel1", a_sel, 4'b1110);
    cyc(1);
    check("restart_sel2", a_sel, 4'b1101);
    check("restart_blank", a_seg, 7'h7F);
    check("restart_noblank", b_seg, 7'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
